// File: rtl/param_updown_counter.sv
// Parametrised modulo-MOD up/down counter with load, enable and wrap/zero flags.
// Optional saturate mode (port sat) is built only when PUDC_SATURATE_EN is defined.
module param_updown_counter #(
   parameter int unsigned WIDTH   = 3,
   parameter int unsigned MOD     = 8,
   parameter int unsigned RST_VAL = MOD - 1
) (
   input  logic             c,
   input  logic             r,
   input  logic             en,
   input  logic             up,
   input  logic             ld,
   input  logic [WIDTH-1:0] din,
`ifdef PUDC_SATURATE_EN
   input  logic             sat,
`endif
   output logic [WIDTH-1:0] c0,
   output logic             tc,
   output logic             zero
);

   localparam int unsigned     XW    = WIDTH + 1;
   localparam logic [XW-1:0]   MOD_X = XW'(MOD);
   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD - 1);
   localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);

   // Elaboration-time guard against an illegal modulus or reset value
   if (WIDTH < 1 || MOD < 2 || 64'(MOD) > (64'd1 << WIDTH) || RST_VAL >= MOD) begin : g_param_err
      $error("param_updown_counter: illegal WIDTH/MOD/RST_VAL combination");
   end

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             tc_q, tc_d;
   logic [XW-1:0]    inc_x;
   logic [WIDTH-1:0] dec_v;

   // Next-state: load > count > hold; increment kept one bit wider so MOD = 2**WIDTH cannot overflow
   always_comb begin
      cnt_d = cnt_q;
      tc_d  = 1'b0;
      inc_x = {1'b0, cnt_q} + XW'(1);
      dec_v = cnt_q - WIDTH'(1);
      if (ld) begin
         cnt_d = ({1'b0, din} < MOD_X) ? din : MAX_V;
`ifdef PUDC_SATURATE_EN
      end else if (en && sat) begin
         if (up) begin
            if (cnt_q != MAX_V) begin
               cnt_d = inc_x[WIDTH-1:0];
               tc_d  = (inc_x[WIDTH-1:0] == MAX_V);
            end
         end else begin
            if (cnt_q != '0) begin
               cnt_d = dec_v;
               tc_d  = (dec_v == '0);
            end
         end
`endif
      end else if (en) begin
         if (up) begin
            tc_d  = (inc_x == MOD_X);
            cnt_d = tc_d ? '0 : inc_x[WIDTH-1:0];
         end else begin
            tc_d  = (cnt_q == '0);
            cnt_d = tc_d ? MAX_V : dec_v;
         end
      end
   end

   always_ff @(posedge c) begin
      if (r) begin
         cnt_q <= RST_V;
         tc_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tc_q  <= tc_d;
      end
   end

   assign c0   = cnt_q;
   assign tc   = tc_q;
   assign zero = (cnt_q == '0);

endmodule

// File: tb/tb_param_updown_counter.sv
// Scoreboard bench: two counter instances (MOD=8 legacy and MOD=10) driven in lockstep
// and compared against an arithmetic reference model.
module tb_param_updown_counter;

   logic       c = 1'b0;
   logic       r = 1'b0, en = 1'b0, up = 1'b0, ld = 1'b0, sat = 1'b0;
   logic [3:0] din = 4'd0;
   logic [2:0] c0_8;
   logic [3:0] c0_10;
   logic       tc_8, tc_10, zero_8, zero_10;

   always #5 c = ~c;

   param_updown_counter #(.WIDTH(3), .MOD(8)) u8 (
      .c(c), .r(r), .en(en), .up(up), .ld(ld), .din(din[2:0]),
`ifdef PUDC_SATURATE_EN
      .sat(sat),
`endif
      .c0(c0_8), .tc(tc_8), .zero(zero_8));

   param_updown_counter #(.WIDTH(4), .MOD(10)) u10 (
      .c(c), .r(r), .en(en), .up(up), .ld(ld), .din(din),
`ifdef PUDC_SATURATE_EN
      .sat(sat),
`endif
      .c0(c0_10), .tc(tc_10), .zero(zero_10));

   typedef struct {
      int c8;
      int t8;
      int c10;
      int t10;
   } exp_t;

   exp_t sb[$];
   int   n_pass = 0, n_total = 0;
   int   m8 = 0, m10 = 0;

   // Reference: counting is arithmetic modulo MOD; saturation clamps at the bound
   function automatic void model(input int md, input int rstv, input int cur,
                                 input bit rr, input bit ll, input int dn,
                                 input bit e, input bit u, input bit s,
                                 output int nxt, output int t);
      nxt = cur;
      t   = 0;
      if (rr) nxt = rstv;
      else if (ll) nxt = (dn < md) ? dn : md - 1;
      else if (e) begin
         if (s && (u ? (cur == md - 1) : (cur == 0))) nxt = cur;
         else if (u) begin
            nxt = (cur + 1) % md;
            t   = s ? int'(nxt == md - 1) : int'(cur + 1 >= md);
         end else begin
            nxt = (cur + md - 1) % md;
            t   = s ? int'(nxt == 0) : int'(cur == 0);
         end
      end
   endfunction

   task automatic drive(input bit rr, input bit ll, input int dn, input bit e,
                        input bit u, input bit s);
      exp_t x;
      int   t;
      @(negedge c);
      r = rr; ld = ll; din = 4'(dn); en = e; up = u;
`ifdef PUDC_SATURATE_EN
      sat = s;
`else
      sat = 1'b0;
`endif
      model(8, 7, m8, rr, ll, dn % 8, e, u, sat, m8, t);
      x.c8 = m8; x.t8 = t;
      model(10, 9, m10, rr, ll, dn, e, u, sat, m10, t);
      x.c10 = m10; x.t10 = t;
      sb.push_back(x);
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
   endtask

   // Monitor: every edge presents a new count; compare against the oldest expectation
   always @(posedge c) begin
      exp_t x;
      #1;
      if (sb.size() > 0) begin
         x = sb.pop_front();
         chk("c0_mod8",    int'(c0_8),    x.c8);
         chk("tc_mod8",    int'(tc_8),    x.t8);
         chk("zero_mod8",  int'(zero_8),  int'(x.c8 == 0));
         chk("c0_mod10",   int'(c0_10),   x.c10);
         chk("tc_mod10",   int'(tc_10),   x.t10);
         chk("zero_mod10", int'(zero_10), int'(x.c10 == 0));
      end
   end

   initial begin
      // reset, then legacy down-count through the 0 -> 7 wrap
      drive(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 9; i++) drive(0, 0, 0, 1, 0, 0);
      // count up from 0 through the MOD=10 wrap
      drive(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 11; i++) drive(0, 0, 0, 1, 1, 0);
      // load clamp, then load beats a concurrent count
      drive(0, 1, 12, 0, 0, 0);
      drive(0, 1, 3, 1, 1, 0);
      // enable gating and mid-sequence direction change
      drive(0, 1, 5, 0, 0, 0);
      drive(0, 0, 0, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 0, 0);
      drive(0, 0, 0, 1, 1, 0);
      // reset wins over load/enable with a wrap pending
      drive(0, 1, 0, 0, 0, 0);
      drive(1, 1, 2, 1, 0, 0);
      drive(0, 0, 0, 1, 1, 0);
`ifdef PUDC_SATURATE_EN
      // saturate at top, release and re-approach
      drive(0, 1, 5, 0, 0, 1);
      for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 1, 1);
      drive(0, 0, 0, 1, 0, 1);
      drive(0, 0, 0, 1, 1, 1);
      drive(0, 0, 0, 1, 1, 1);
`endif
      for (int i = 0; i < 600; i++)
         drive($urandom_range(49) == 0, $urandom_range(7) == 0, $urandom_range(15),
               $urandom_range(3) != 0, $urandom_range(1) == 1, $urandom_range(1) == 1);
      drive(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge c);
      #2;
      if (sb.size() != 0) begin
         n_total++;
         $display("FAIL drain: got %0d pending, expected 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
